// File: rtl/bullet_pool_pkg.sv
// Shared definitions for the bullet pool: color codes, the slot record and
// default geometry/playfield constants.
package bullet_pool_pkg;

    localparam int DEF_N_SLOTS   = 8;
    localparam int DEF_COORD_W   = 8;
    localparam int DEF_SIZE_W    = 8;
    localparam int DEF_COLOR_W   = 3;
    localparam int DEF_Y_MIN     = 1;
    localparam int DEF_Y_MAX     = 200;
    localparam int DEF_WRAP_MODE = 1;

    localparam logic [DEF_COLOR_W-1:0] COLOR_WHITE = 3'd0;
    localparam logic [DEF_COLOR_W-1:0] COLOR_GREEN = 3'd1;
    localparam logic [DEF_COLOR_W-1:0] COLOR_BLUE  = 3'd2;

    // One bullet slot at the default geometry; the top builds the same
    // layout from its own width parameters.
    typedef struct packed {
        logic                           alive;
        logic        [DEF_COLOR_W-1:0]  color;
        logic signed [DEF_COORD_W-1:0]  vy;
        logic        [DEF_SIZE_W-1:0]   w;
        logic        [DEF_SIZE_W-1:0]   h;
        logic        [DEF_COORD_W-1:0]  x;
        logic        [DEF_COORD_W-1:0]  y;
    } slot_t;

endpackage

// File: rtl/bullet_pool_alloc.sv
// Lowest-index free-slot priority encoder for the bullet pool.
module bullet_pool_alloc
    import bullet_pool_pkg::*;
#(
    parameter  int N_SLOTS = DEF_N_SLOTS,
    localparam int IDX_W   = $clog2(N_SLOTS)
) (
    input  logic [N_SLOTS-1:0] alive,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest dead slot wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!alive[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: fixed set of bullet slots with spawn, kill and per-tick
// vertical movement, plus two combinational read ports.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter  int N_SLOTS   = DEF_N_SLOTS,
    parameter  int COORD_W   = DEF_COORD_W,
    parameter  int SIZE_W    = DEF_SIZE_W,
    parameter  int COLOR_W   = DEF_COLOR_W,
    parameter  int Y_MIN     = DEF_Y_MIN,
    parameter  int Y_MAX     = DEF_Y_MAX,
    parameter  int WRAP_MODE = DEF_WRAP_MODE,
    localparam int IDX_W     = $clog2(N_SLOTS),
    localparam int CNT_W     = $clog2(N_SLOTS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic                      tick,
    input  logic                      spawn_valid,
    output logic                      spawn_ready,
    input  logic [COORD_W-1:0]        spawn_x,
    input  logic [COORD_W-1:0]        spawn_y,
    input  logic [SIZE_W-1:0]         spawn_w,
    input  logic [SIZE_W-1:0]         spawn_h,
    input  logic [COLOR_W-1:0]        spawn_color,
    input  logic signed [COORD_W-1:0] spawn_vy,
    input  logic                      kill_valid,
    input  logic [IDX_W-1:0]          kill_idx,
    input  logic [IDX_W-1:0]          rd_idx_a,
    input  logic [IDX_W-1:0]          rd_idx_b,
    output logic [2*COORD_W-1:0]      pos_a,
    output logic [2*SIZE_W-1:0]       size_a,
    output logic [COLOR_W-1:0]        color_a,
    output logic                      alive_a,
    output logic [2*COORD_W-1:0]      pos_b,
    output logic [2*SIZE_W-1:0]       size_b,
    output logic [COLOR_W-1:0]        color_b,
    output logic                      alive_b,
    output logic [N_SLOTS-1:0]        alive_mask,
    output logic [CNT_W-1:0]          alive_count
);

    typedef struct packed {
        logic                      alive;
        logic        [COLOR_W-1:0] color;
        logic signed [COORD_W-1:0] vy;
        logic        [SIZE_W-1:0]  w;
        logic        [SIZE_W-1:0]  h;
        logic        [COORD_W-1:0] x;
        logic        [COORD_W-1:0] y;
    } slot_rec_t;

    slot_rec_t          slot_q [N_SLOTS];
    slot_rec_t          slot_d [N_SLOTS];
    logic [N_SLOTS-1:0] alive_vec;
    logic               alloc_found;
    logic [IDX_W-1:0]   alloc_idx;
    logic               spawn_fire;
    logic               kill_hit;
    logic [COORD_W:0]   mv;

    // Advance y by vy in one extra signed bit and resolve the playfield
    // bound; returns {still_alive, new_y}. A retired bullet keeps its old y.
    function automatic logic [COORD_W:0] step_y(input logic [COORD_W-1:0] y,
                                                input logic signed [COORD_W-1:0] vy);
        logic signed [COORD_W:0] sum;
        logic signed [COORD_W:0] lo;
        logic signed [COORD_W:0] hi;
        logic                    keep;
        logic [COORD_W-1:0]      ny;
        sum  = $signed({1'b0, y}) + $signed({vy[COORD_W-1], vy});
        lo   = $signed((COORD_W+1)'(Y_MIN));
        hi   = $signed((COORD_W+1)'(Y_MAX));
        keep = 1'b1;
        ny   = sum[COORD_W-1:0];
        if (sum > hi) begin
            if (WRAP_MODE != 0) ny = COORD_W'(Y_MIN);
            else begin keep = 1'b0; ny = y; end
        end else if (sum < lo) begin
            if (WRAP_MODE != 0) ny = COORD_W'(Y_MAX);
            else begin keep = 1'b0; ny = y; end
        end
        return {keep, ny};
    endfunction

    bullet_pool_alloc #(.N_SLOTS(N_SLOTS)) u_alloc (
        .alive (alive_vec),
        .found (alloc_found),
        .idx   (alloc_idx)
    );

    // Registered alive bits, population count and handshake/kill qualifiers.
    always_comb begin
        alive_count = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            alive_vec[i] = slot_q[i].alive;
            alive_count  = alive_count + CNT_W'(slot_q[i].alive);
        end
        alive_mask  = alive_vec;
        spawn_ready = run & alloc_found;
        spawn_fire  = spawn_valid & spawn_ready;
        kill_hit    = run & kill_valid &
                      ({1'b0, kill_idx} < (IDX_W+1)'(N_SLOTS)) & alive_vec[kill_idx];
    end

    // Next slot state: flush when not running, else kill beats move, and
    // a spawn lands in a slot that was dead before this edge.
    always_comb begin
        mv = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            if (!run) begin
                slot_d[i].alive = 1'b0;
            end else begin
                if (kill_hit && kill_idx == IDX_W'(i)) begin
                    slot_d[i].alive = 1'b0;
                end else if (tick && slot_q[i].alive) begin
                    mv              = step_y(slot_q[i].y, slot_q[i].vy);
                    slot_d[i].y     = mv[COORD_W-1:0];
                    slot_d[i].alive = mv[COORD_W];
                end
                if (spawn_fire && alloc_idx == IDX_W'(i)) begin
                    slot_d[i].alive = 1'b1;
                    slot_d[i].color = spawn_color;
                    slot_d[i].vy    = spawn_vy;
                    slot_d[i].w     = spawn_w;
                    slot_d[i].h     = spawn_h;
                    slot_d[i].x     = spawn_x;
                    slot_d[i].y     = spawn_y;
                end
            end
        end
    end

    // Slot registers; reset zeroes every field and alive bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= slot_d[i];
        end
    end

    // Combinational read ports; out-of-range indices read as zero.
    always_comb begin
        pos_a = '0; size_a = '0; color_a = '0; alive_a = 1'b0;
        pos_b = '0; size_b = '0; color_b = '0; alive_b = 1'b0;
        if ({1'b0, rd_idx_a} < (IDX_W+1)'(N_SLOTS)) begin
            pos_a   = {slot_q[rd_idx_a].x, slot_q[rd_idx_a].y};
            size_a  = {slot_q[rd_idx_a].w, slot_q[rd_idx_a].h};
            color_a = slot_q[rd_idx_a].color;
            alive_a = slot_q[rd_idx_a].alive;
        end
        if ({1'b0, rd_idx_b} < (IDX_W+1)'(N_SLOTS)) begin
            pos_b   = {slot_q[rd_idx_b].x, slot_q[rd_idx_b].y};
            size_b  = {slot_q[rd_idx_b].w, slot_q[rd_idx_b].h};
            color_b = slot_q[rd_idx_b].color;
            alive_b = slot_q[rd_idx_b].alive;
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: two instances (wrap and retire mode)
// share stimulus; directed scenarios queue hand-computed expectations.
module tb_bullet_pool;
    import bullet_pool_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, run, tick, spawn_valid, kill_valid;
    logic [7:0]  spawn_x, spawn_y, spawn_w, spawn_h;
    logic signed [7:0] spawn_vy;
    logic [2:0]  spawn_color, kill_idx, rd_idx_a, rd_idx_b;

    logic        spawn_ready, alive_a, alive_b;
    logic [15:0] pos_a, size_a, pos_b, size_b;
    logic [2:0]  color_a, color_b;
    logic [7:0]  alive_mask;
    logic [3:0]  alive_count;

    logic        r_spawn_ready, r_alive_a, r_alive_b;
    logic [15:0] r_pos_a, r_size_a, r_pos_b, r_size_b;
    logic [2:0]  r_color_a, r_color_b;
    logic [7:0]  r_alive_mask;
    logic [3:0]  r_alive_count;

    always #5 clk = ~clk;

    bullet_pool #(.WRAP_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .tick(tick),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_w(spawn_w), .spawn_h(spawn_h),
        .spawn_color(spawn_color), .spawn_vy(spawn_vy),
        .kill_valid(kill_valid), .kill_idx(kill_idx),
        .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
        .pos_a(pos_a), .size_a(size_a), .color_a(color_a), .alive_a(alive_a),
        .pos_b(pos_b), .size_b(size_b), .color_b(color_b), .alive_b(alive_b),
        .alive_mask(alive_mask), .alive_count(alive_count)
    );

    bullet_pool #(.WRAP_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .tick(tick),
        .spawn_valid(spawn_valid), .spawn_ready(r_spawn_ready),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_w(spawn_w), .spawn_h(spawn_h),
        .spawn_color(spawn_color), .spawn_vy(spawn_vy),
        .kill_valid(kill_valid), .kill_idx(kill_idx),
        .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
        .pos_a(r_pos_a), .size_a(r_size_a), .color_a(r_color_a), .alive_a(r_alive_a),
        .pos_b(r_pos_b), .size_b(r_size_b), .color_b(r_color_b), .alive_b(r_alive_b),
        .alive_mask(r_alive_mask), .alive_count(r_alive_count)
    );

    localparam int S_POS = 0, S_ALIVE = 1, S_MASK = 2, S_COUNT = 3, S_READY = 4,
                   S_SIZE = 5, S_COLOR = 6, S_PORTB = 7, S_R_ALIVE = 8,
                   S_R_POS = 9, S_R_MASK = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } item_t;

    item_t q[$];
    logic  probe = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;

    // Monitor: whenever a probe is presented, pop one expectation and compare.
    always @(negedge clk) begin
        if (probe) begin
            item_t       it;
            logic [63:0] act;
            n_cmp = n_cmp + 1;
            if (q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL scoreboard_underflow: probe with no expectation queued");
            end else begin
                it = q.pop_front();
                case (it.sel)
                    S_POS:     act = 64'(pos_a);
                    S_ALIVE:   act = 64'(alive_a);
                    S_MASK:    act = 64'(alive_mask);
                    S_COUNT:   act = 64'(alive_count);
                    S_READY:   act = 64'(spawn_ready);
                    S_SIZE:    act = 64'(size_a);
                    S_COLOR:   act = 64'(color_a);
                    S_PORTB:   act = 64'({pos_b, size_b, color_b, alive_b});
                    S_R_ALIVE: act = 64'(r_alive_a);
                    S_R_POS:   act = 64'(r_pos_a);
                    S_R_MASK:  act = 64'(r_alive_mask);
                    default:   act = '1;
                endcase
                if (act !== it.exp) begin
                    n_err = n_err + 1;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int sel, input logic [2:0] idx,
                       input logic [63:0] exp);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        q.push_back(it);
        rd_idx_a = idx;
        rd_idx_b = idx;
        probe    = 1'b1;
        cyc();
        probe    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic spawn(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] vy, input logic [2:0] c);
        spawn_valid = 1'b1;
        spawn_x = x; spawn_y = y; spawn_vy = vy; spawn_color = c;
        spawn_w = 8'd16; spawn_h = 8'd16;
        cyc();
        spawn_valid = 1'b0;
    endtask

    task automatic kill(input logic [2:0] idx);
        kill_valid = 1'b1;
        kill_idx   = idx;
        cyc();
        kill_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b1; tick = 1'b0; spawn_valid = 1'b0; kill_valid = 1'b0;
        spawn_x = '0; spawn_y = '0; spawn_w = '0; spawn_h = '0; spawn_vy = '0;
        spawn_color = '0; kill_idx = '0; rd_idx_a = '0; rd_idx_b = '0;
        cyc();
        do_reset();

        // Reset state
        chk("rst_mask",  S_MASK,  3'd0, 64'h0);
        chk("rst_count", S_COUNT, 3'd0, 64'h0);
        chk("rst_ready", S_READY, 3'd0, 64'h1);
        chk("rst_pos",   S_POS,   3'd5, 64'h0);
        chk("rst_portb", S_PORTB, 3'd0, 64'h0);

        // Basic spawn into slot 0, then one tick
        spawn(8'd160, 8'd19, 8'd5, COLOR_GREEN);
        chk("sp_pos",   S_POS,   3'd0, 64'hA013);
        chk("sp_alive", S_ALIVE, 3'd0, 64'h1);
        chk("sp_count", S_COUNT, 3'd0, 64'h1);
        chk("sp_size",  S_SIZE,  3'd0, 64'h1010);
        chk("sp_color", S_COLOR, 3'd0, 64'h1);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("tick_pos", S_POS,   3'd0, 64'hA018);

        // Crossing Y_MAX: wrap to Y_MIN vs retire
        do_reset();
        spawn(8'd160, 8'd198, 8'd5, COLOR_WHITE);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("wrap_hi_pos",     S_POS,     3'd0, 64'hA001);
        chk("retire_hi_alive", S_R_ALIVE, 3'd0, 64'h0);

        // Crossing Y_MIN downward, and landing exactly on Y_MAX
        do_reset();
        spawn(8'd10, 8'd3, 8'hFB, COLOR_BLUE);
        spawn(8'd20, 8'd195, 8'd5, COLOR_BLUE);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("wrap_lo_pos",     S_POS,     3'd0, 64'h0AC8);
        chk("edge_max_pos",    S_POS,     3'd1, 64'h14C8);
        chk("retire_lo_mask",  S_R_MASK,  3'd0, 64'h2);
        chk("retired_keeps_y", S_R_POS,   3'd0, 64'h0A03);
        chk("edge_max_alive",  S_R_ALIVE, 3'd1, 64'h1);

        // Fill the pool, refuse a 9th spawn, free slot 3 and refill it
        do_reset();
        for (int i = 0; i < 8; i++) spawn(8'(i), 8'(50 + i), 8'd1, COLOR_WHITE);
        chk("full_ready", S_READY, 3'd0, 64'h0);
        spawn(8'd99, 8'd99, 8'd1, COLOR_GREEN);
        chk("full_mask",  S_MASK,  3'd0, 64'hFF);
        chk("full_count", S_COUNT, 3'd0, 64'h8);
        chk("full_pos0",  S_POS,   3'd0, 64'h0032);
        chk("full_pos7",  S_POS,   3'd7, 64'h0739);
        kill(3'd3);
        chk("kill_mask",  S_MASK,  3'd0, 64'hF7);
        chk("kill_count", S_COUNT, 3'd0, 64'h7);
        chk("kill_ready", S_READY, 3'd0, 64'h1);
        spawn(8'hAA, 8'd100, 8'd0, COLOR_BLUE);
        chk("reuse_pos",   S_POS,   3'd3, 64'hAA64);
        chk("reuse_color", S_COLOR, 3'd3, 64'h2);
        chk("reuse_mask",  S_MASK,  3'd0, 64'hFF);

        // Tick, kill and spawn in one cycle
        do_reset();
        for (int i = 0; i < 3; i++) spawn(8'(i), 8'd10, 8'd2, COLOR_WHITE);
        tick = 1'b1;
        kill_valid = 1'b1; kill_idx = 3'd2;
        spawn_valid = 1'b1; spawn_x = 8'h33; spawn_y = 8'd40; spawn_vy = 8'd3;
        spawn_w = 8'd16; spawn_h = 8'd16; spawn_color = COLOR_GREEN;
        cyc();
        tick = 1'b0; kill_valid = 1'b0; spawn_valid = 1'b0;
        chk("mix_pos0",   S_POS,   3'd0, 64'h000C);
        chk("mix_pos1",   S_POS,   3'd1, 64'h010C);
        chk("mix_alive2", S_ALIVE, 3'd2, 64'h0);
        chk("mix_pos2",   S_POS,   3'd2, 64'h020A);
        chk("mix_pos3",   S_POS,   3'd3, 64'h3328);
        chk("mix_mask",   S_MASK,  3'd0, 64'h0B);
        chk("mix_count",  S_COUNT, 3'd0, 64'h3);

        // Asynchronous reset during a tick, then run-low flush
        do_reset();
        for (int i = 0; i < 5; i++) spawn(8'(i), 8'd20, 8'd1, COLOR_WHITE);
        chk("five_mask", S_MASK, 3'd0, 64'h1F);
        tick = 1'b1;
        rst_n = 1'b0;
        chk("async_rst_mask", S_MASK, 3'd0, 64'h0);
        chk("async_rst_pos",  S_POS,  3'd0, 64'h0);
        tick = 1'b0;
        rst_n = 1'b1;
        chk("post_rst_ready", S_READY, 3'd0, 64'h1);
        for (int i = 0; i < 5; i++) spawn(8'(i), 8'd20, 8'd1, COLOR_WHITE);
        run = 1'b0;
        chk("run_low_pre",   S_MASK,  3'd0, 64'h1F);
        chk("run_low_mask",  S_MASK,  3'd0, 64'h0);
        chk("run_low_ready", S_READY, 3'd0, 64'h0);
        chk("run_low_field", S_POS,   3'd4, 64'h0414);
        run = 1'b1;
        chk("run_high_ready", S_READY, 3'd0, 64'h1);

        repeat (2) cyc();
        n_cmp = n_cmp + 1;
        if (q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
